// File: rtl/aes_gf_pkg.sv
// rtl/aes_gf_pkg.sv - shared constants, state type and AES affine map for the GF(2^8) inverse engine
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY     = 8'h1b;
  localparam logic [7:0] AES_AFFINE_C = 8'h63;
  localparam int         INV_STEPS    = 13;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, indices mod 8
  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
           ^ b[(i + 7) % 8] ^ AES_AFFINE_C[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_mul8.sv
// rtl/gf_mul8.sv - combinational GF(2^8) multiplier, product reduced modulo x^8+POLY
module gf_mul8 #(
  parameter logic [7:0] POLY = 8'h1b
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] p;
  logic [7:0] a_sh;

  // Shift-and-add: a_sh holds a*x^i already reduced, so the product never exceeds 8 bits
  always_comb begin
    p    = 8'h00;
    a_sh = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        p = p ^ a_sh;
      end
      a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? POLY : 8'h00);
    end
    p_o = p;
  end

endmodule

// File: rtl/aes_gf_inv.sv
// rtl/aes_gf_inv.sv - sequential GF(2^8) inverse a^254 by square-and-multiply; AES_GF_INV_AFFINE_EN adds the S-box affine map
module aes_gf_inv
  import aes_gf_pkg::*;
#(
  parameter logic [7:0] POLY = AES_POLY
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       busy_o
);

  state_t     state_q, state_d;
  logic [3:0] step_q;
  logic [3:0] step_nxt;
  logic [7:0] acc_q;
  logic [7:0] op_q;
  logic [7:0] res_q;
  logic [7:0] prod;
  logic [7:0] mul_b;
  logic [7:0] res_d;
  logic       last_step;

  assign step_nxt  = step_q + 4'd1;
  assign last_step = (step_nxt == 4'(INV_STEPS));
  // Odd steps square, even steps multiply by the original operand
  assign mul_b     = step_nxt[0] ? acc_q : op_q;

  gf_mul8 #(.POLY(POLY)) u_mul (
    .a_i (acc_q),
    .b_i (mul_b),
    .p_o (prod)
  );

`ifdef AES_GF_INV_AFFINE_EN
  assign res_d = aes_affine(prod);
`else
  assign res_d = prod;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step_q <= 4'd0;
      acc_q  <= 8'h00;
      op_q   <= 8'h00;
      res_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q   <= data_i;
            acc_q  <= data_i;
            step_q <= 4'd0;
          end
        end
        CALC: begin
          acc_q  <= prod;
          step_q <= step_nxt;
          if (last_step) res_q <= res_d;
        end
        default: ;
      endcase
    end
  end

  assign data_o = res_q;

endmodule

// File: tb/tb_aes_gf_inv.sv
// tb/tb_aes_gf_inv.sv - scoreboard bench for aes_gf_inv against a brute-force GF(2^8) inverse / S-box model
module tb_aes_gf_inv;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         lat_q[$];

  aes_gf_inv dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int gmul(int a, int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ x;
      x = x << 1;
      if (x & 'h100) x = x ^ 'h11b;
    end
    return p;
  endfunction

  function automatic int ginv(int a);
    for (int x = 1; x < 256; x++) if (gmul(a, x) == 1) return x;
    return 0;
  endfunction

  function automatic int rotl(int b, int k);
    return ((b << k) | (b >> (8 - k))) & 'hff;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] a);
    int b;
    b = ginv(int'(a));
`ifdef AES_GF_INV_AFFINE_EN
    b = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 'h63;
`endif
    return b[7:0];
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] e, output int acc_cyc);
    int n = 0;
    @(posedge clk_i); #1;
    valid_i = 1'b1;
    data_i  = a;
    while (!ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) begin
      check("send_timeout", 0, 1);
      valid_i = 1'b0;
      acc_cyc = cyc;
    end else begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      acc_cyc = cyc;
      exp_q.push_back(e);
      lat_q.push_back(cyc);
    end
  endtask

  // Monitor: latency on valid rise, hold stability in DONE, data compare on consume
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_o && !prev_valid) begin
        if (lat_q.size() == 0) check("unexpected_result", 1, 0);
        else check("latency", cyc - lat_q.pop_front(), 13);
      end
      if (valid_o && prev_valid) check("data_hold", data_o, prev_data);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("extra_result", 1, 0);
        else check("result", data_o, exp_q.pop_front());
      end
      prev_valid = valid_o;
      prev_data  = data_o;
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int t, tprev, n;
    logic [7:0] a;
    logic [7:0] vin[$];
    logic [7:0] vex[$];

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", data_o, 0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      check("idle_state", {ready_o, valid_o, busy_o}, 3'b100);
      check("idle_data", data_o, 0);
    end

`ifdef AES_GF_INV_AFFINE_EN
    vin = '{8'h00, 8'h01, 8'h53};
    vex = '{8'h63, 8'h7c, 8'hed};
`else
    vin = '{8'h53, 8'hca, 8'h02, 8'h01, 8'h00};
    vex = '{8'hca, 8'h53, 8'h8d, 8'h01, 8'h00};
`endif
    for (int i = 0; i < vin.size(); i++) begin
      send(vin[i], vex[i], t);
      @(posedge clk_i); #1;
      check("busy_after_accept", busy_o, 1);
    end
    drain();

    // Backpressure with an ignored 0xFF pulse
    ready_i = 1'b0;
    send(8'h53, model(8'h53), t);
    n = 0;
    while (!valid_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("bp_valid_seen", valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("bp_valid", valid_o, 1);
      check("bp_ready", ready_o, 0);
      if (i == 3) begin
        valid_i = 1'b1;
        data_i  = 8'hff;
      end
      if (i == 4) valid_i = 1'b0;
    end
    ready_i = 1'b1;
    drain();
    @(posedge clk_i); #1;
    check("bp_ready_back", ready_o, 1);
    check("bp_no_extra", valid_o, 0);

    // Back-to-back with ready_i high
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(0, 255));
      send(a, model(a), t);
      if (k > 0) check("issue_interval", t - tprev, 15);
      tprev = t;
    end
    drain();

    // Async reset mid-CALC at step 6
    send(8'h37, model(8'h37), t);
    repeat (6) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_ready", ready_o, 1);
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_data", data_o, 0);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    send(8'h53, model(8'h53), t);
    drain();

    // Exhaustive sweep then random operands
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      send(a, model(a), t);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom());
      send(a, model(a), t);
    end
    drain();
    check("latency_queue_empty", lat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
